// File: rtl/sccomp_dmem_pkg.sv
// Shared encodings, FSM state type and access-legality check for the sccomp data memory.
package sccomp_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } dmem_req_t;

    // oor is precomputed by the caller since it depends on DEPTH and the address width
    function automatic logic access_err(input logic [1:0] a_lo, input logic [1:0] size,
                                        input logic oor);
        case (size)
            SZ_BYTE: access_err = oor;
            SZ_HALF: access_err = oor | a_lo[0];
            SZ_WORD: access_err = oor | (a_lo != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sccomp_dmem_subword.sv
// Byte-lane steering: store byte-enables/replicated data and load extraction with extension.
module dmem_subword
    import sccomp_mem_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 8
) (
    input  logic [1:0]                          a_lo,
    input  logic [1:0]                          size,
    input  logic                                uns,
    input  logic [NUM_LANES*VEC_W-1:0]          wdata,
    input  logic [NUM_LANES*VEC_W-1:0]          rword,
    output logic [NUM_LANES-1:0]                be,
    output logic [NUM_LANES-1:0][VEC_W-1:0]     wlanes,
    output logic [NUM_LANES*VEC_W-1:0]          rdata
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LI = 2'(i);
        assign be[i] = (size == SZ_WORD)
                     | ((size == SZ_HALF) & (a_lo[1] == LI[1]))
                     | ((size == SZ_BYTE) & (a_lo == LI));
        // sub-word data is replicated so every enabled lane already holds the right bits
        assign wlanes[i] = (size == SZ_WORD) ? wdata[VEC_W*i +: VEC_W]
                         : (size == SZ_HALF) ? wdata[VEC_W*(i%2) +: VEC_W]
                         : wdata[VEC_W-1:0];
    end

    logic [NUM_LANES*VEC_W-1:0] shifted;

    always_comb begin
        shifted = rword >> {a_lo, 3'b000};
        case (size)
            SZ_BYTE: rdata = {{24{~uns & shifted[7]}},  shifted[7:0]};
            SZ_HALF: rdata = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: rdata = rword;
        endcase
    end

endmodule

// File: rtl/sccomp_dmem.sv
// Handshaked data memory with programmable wait states, sub-word access and debug readout.
module sccomp_dmem
    import sccomp_mem_pkg::*;
#(
    parameter int    DEPTH       = 128,
    parameter int    ADDR_W      = 32,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    input  logic [$clog2(DEPTH)-1:0] dbg_sel,
    output logic [31:0]              dbg_data
);

    localparam int AW = $clog2(DEPTH);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              enter_resp;
    dmem_req_t         req_in, req_q, eff;
    logic [ADDR_W-1:0] addr_q, eff_addr;
    logic [31:0]       mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // with zero wait states RESP is entered on the accept edge, so the live inputs are used
    assign req_in   = '{we: req_we, size: req_size, uns: req_unsigned, wdata: req_wdata};
    assign eff      = (state == IDLE) ? req_in : req_q;
    assign eff_addr = (state == IDLE) ? req_addr : addr_q;

    logic          accept, oor, err;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [3:0][7:0] wlanes;
    logic [31:0]   ld_data;

    assign accept = (state == IDLE) & req_valid & req_ready;
    assign oor    = |(eff_addr >> (AW + 2));
    assign err    = access_err(eff_addr[1:0], eff.size, oor);
    assign widx   = eff_addr[AW+1:2];

    dmem_subword u_subword (
        .a_lo  (eff_addr[1:0]),
        .size  (eff.size),
        .uns   (eff.uns),
        .wdata (eff.wdata),
        .rword (mem[widx]),
        .be    (be),
        .wlanes(wlanes),
        .rdata (ld_data)
    );

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (WAIT_CYCLES == 0) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = 4'(WAIT_CYCLES - 1);
                end
            end
            WAIT: if (cnt == 4'd0) begin
                state_nx   = RESP;
                enter_resp = 1'b1;
            end else begin
                cnt_nx = cnt - 4'd1;
            end
            RESP: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= (state_nx == IDLE);
            if (accept) begin
                req_q  <= req_in;
                addr_q <= req_addr;
            end
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= err;
                resp_rdata <= (err | eff.we) ? '0 : ld_data;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && enter_resp && eff.we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wlanes[i];
    end

    assign dbg_data = mem[dbg_sel];

endmodule

// File: tb/tb_sccomp_dmem.sv
// Two instances (0 and 3 wait states) checked against a byte-array memory model.
module tb_sccomp_dmem;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn[2], req_valid[2], req_ready[2], req_we[2], req_unsigned[2];
    logic [31:0]   req_addr[2], req_wdata[2], resp_rdata[2], dbg_data[2];
    logic [1:0]    req_size[2];
    logic          resp_valid[2], resp_ready[2], resp_err[2];
    logic [AW-1:0] dbg_sel[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sccomp_dmem #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(g*3)) u_dut (
            .clk         (clk),
            .rstn        (rstn[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_we      (req_we[g]),
            .req_addr    (req_addr[g]),
            .req_size    (req_size[g]),
            .req_unsigned(req_unsigned[g]),
            .req_wdata   (req_wdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_err    (resp_err[g]),
            .dbg_sel     (dbg_sel[g]),
            .dbg_data    (dbg_data[g])
        );
    end

    logic [7:0] mb [2][DEPTH*4];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: memory as a flat little-endian byte array
    task automatic model(input int d, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        rd = '0;
        if (size == 2'd3) begin
            er = 1'b1;
        end else begin
            n  = 1 << size;
            er = (addr % n != 0) || (addr >= DEPTH*4);
            if (!er && we) begin
                for (int b = 0; b < n; b++) mb[d][addr+b] = wd[8*b +: 8];
            end else if (!er) begin
                v = '0;
                for (int b = 0; b < n; b++) v[8*b +: 8] = mb[d][addr+b];
                if (!uns && n < 4 && v[8*n-1])
                    for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
                rd = v;
            end
        end
    endtask

    task automatic chk_dbg(input int d, input int w);
        dbg_sel[d] = AW'(w);
        #1;
        chk($sformatf("dbg%0d[%0d]", d, w), dbg_data[d],
            {mb[d][4*w+3], mb[d][4*w+2], mb[d][4*w+1], mb[d][4*w]});
    endtask

    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wd,
                          input int hold, output logic [31:0] got, output int acc_wait);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          lat;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_size[d] = size; req_unsigned[d] = uns; req_wdata[d] = wd;
        acc_wait = 0;
        while (!req_ready[d] && acc_wait < 50) begin @(negedge clk); acc_wait++; end
        chk("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
        if (hold > 0) resp_ready[d] = 1'b0;
        @(posedge clk); #1;
        model(d, we, addr, size, uns, wd, exp_rd, exp_er);
        // scramble inputs after acceptance; they must have no effect
        req_valid[d] = 1'b0; req_addr[d] = $urandom; req_wdata[d] = $urandom;
        req_we[d] = 1'($urandom); req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid[d] && lat < 40);
        chk("latency", 32'(lat), 32'(1 + d*3));
        chk("rdata", resp_rdata[d], exp_rd);
        chk("err", 32'(resp_err[d]), 32'(exp_er));
        chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
        got = resp_rdata[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid[d]), 32'd1);
            chk("hold_rdata", resp_rdata[d], exp_rd);
            chk("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        chk("resp_drop", 32'(resp_valid[d]), 32'd0);
        chk("req_ready_back", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] got, a;
        logic [1:0]  sz;
        int          aw;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH*4; i++) mb[d][i] = 8'h00;
            rstn[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_size[d] = '0; req_unsigned[d] = 1'b0; req_wdata[d] = '0;
            resp_ready[d] = 1'b1; dbg_sel[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
        end
        @(negedge clk); rstn[0] = 1'b1; rstn[1] = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready0", 32'(req_ready[0]), 32'd1);
        chk("post_rst_ready1", 32'(req_ready[1]), 32'd1);

        // word store/load and sub-word lanes, zero wait states
        do_req(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, got, aw);
        chk_dbg(0, 4);
        chk("tp_dbg4", dbg_data[0], 32'hDEADBEEF);
        do_req(0, 0, 32'h10, 2'b10, 0, 0, 0, got, aw);
        chk("tp_lw", got, 32'hDEADBEEF);
        chk("b2b_accept", 32'(aw), 32'd0);
        do_req(0, 1, 32'h11, 2'b00, 0, 32'h00000080, 0, got, aw);
        do_req(0, 0, 32'h11, 2'b00, 0, 0, 0, got, aw);
        chk("tp_lb_s", got, 32'hFFFFFF80);
        do_req(0, 0, 32'h11, 2'b00, 1, 0, 0, got, aw);
        chk("tp_lb_u", got, 32'h00000080);
        do_req(0, 0, 32'h10, 2'b10, 1, 0, 0, got, aw);
        chk("tp_lw2", got, 32'hDEAD80EF);
        do_req(0, 0, 32'h12, 2'b01, 0, 0, 0, got, aw);
        chk("tp_lh_s", got, 32'hFFFFDEAD);

        // error cases leave memory untouched
        do_req(0, 1, 32'h12, 2'b10, 0, 32'h11112222, 0, got, aw);
        do_req(0, 0, 32'h13, 2'b01, 0, 0, 0, got, aw);
        do_req(0, 1, 32'h10, 2'b11, 0, 32'h33334444, 0, got, aw);
        do_req(0, 1, 32'(DEPTH*4), 2'b10, 0, 32'h55556666, 0, got, aw);
        chk_dbg(0, 4);
        chk_dbg(0, 5);
        chk_dbg(0, DEPTH-1);

        // three wait states with response backpressure
        do_req(1, 1, 32'h40, 2'b10, 0, 32'hCAFEF00D, 0, got, aw);
        do_req(1, 0, 32'h42, 2'b01, 1, 0, 5, got, aw);
        chk("bp_lh_u", got, 32'h0000CAFE);
        do_req(1, 0, 32'h40, 2'b00, 0, 0, 0, got, aw);
        chk("bp_next_accept", 32'(aw), 32'd0);

        // reset while a store waits: no write happens
        chk_dbg(1, 8);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
        req_size[1] = 2'b10; req_unsigned[1] = 1'b0; req_wdata[1] = 32'h12345678;
        chk("mr_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk); rstn[1] = 1'b0;
        @(posedge clk); #1;
        chk("mr_ready_low", 32'(req_ready[1]), 32'd0);
        chk("mr_valid_low", 32'(resp_valid[1]), 32'd0);
        @(negedge clk); rstn[1] = 1'b1;
        @(posedge clk); #1;
        chk("mr_ready_up", 32'(req_ready[1]), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("mr_no_resp", 32'(resp_valid[1]), 32'd0);
        chk_dbg(1, 8);
        chk("mr_mem8", dbg_data[1], 32'h00000000);

        // randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 60; t++) begin
                sz = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 7));
                if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
                do_req(d, 1'($urandom), a, sz, 1'($urandom), $urandom, 0, got, aw);
                chk_dbg(d, int'($urandom_range(0, DEPTH-1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
